// File: rtl/chan_scan_mux.sv
// chan_scan_mux: registered N_CH-way channel multiplexer with a manual-select
// mode and an auto-scan mode that presents each channel for dwell+1 cycles.
module chan_scan_mux #(
    parameter int unsigned N_CH = 8,
    parameter int unsigned W    = 1
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic [N_CH*W-1:0]         d,
    input  logic [$clog2(N_CH)-1:0]   s,
    input  logic                      mode,
    input  logic                      en,
    input  logic [7:0]                dwell,
    output logic [W-1:0]              y,
    output logic [$clog2(N_CH)-1:0]   ch,
    output logic                      y_valid,
    output logic                      wrap
);

    localparam int unsigned SEL_W = $clog2(N_CH);
    localparam int unsigned CNT_W = 8;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_MANUAL = 2'd1,
        ST_SCAN   = 2'd2
    } state_t;

    // Registered state
    state_t             r_state;
    logic [SEL_W-1:0]   r_ptr;
    logic [CNT_W-1:0]   r_cnt;
    logic               r_last_scan;
    logic [W-1:0]       r_y;
    logic [SEL_W-1:0]   r_ch;
    logic               r_y_valid;
    logic               r_wrap;

    // Next-cycle values
    state_t             w_state_nxt;
    logic [SEL_W-1:0]   w_ptr_nxt;
    logic [CNT_W-1:0]   w_cnt_nxt;
    logic               w_last_scan_nxt;
    logic [W-1:0]       w_y_nxt;
    logic [SEL_W-1:0]   w_ch_nxt;
    logic               w_y_valid_nxt;
    logic               w_wrap_nxt;

    // Scan helpers and data mux
    logic               w_restart;
    logic               w_adv;
    logic               w_scan_wrap;
    logic [SEL_W-1:0]   w_scan_ptr;
    logic [CNT_W-1:0]   w_scan_cnt;
    logic [SEL_W-1:0]   w_sel;
    logic [W-1:0]       w_sel_data;

    // State register
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // Next state is a pure function of en/mode, re-evaluated every cycle
    always_comb begin
        w_state_nxt = ST_IDLE;
        if (en) begin
            w_state_nxt = mode ? ST_SCAN : ST_MANUAL;
        end
    end

    // Scan position step: restart unless we are continuing or resuming a scan;
    // the >= compare lets a shrunk dwell advance immediately
    always_comb begin
        w_restart   = (r_state == ST_MANUAL) ||
                      ((r_state == ST_IDLE) && !r_last_scan);
        w_adv       = (r_cnt >= dwell);
        w_scan_ptr  = r_ptr;
        w_scan_cnt  = r_cnt;
        w_scan_wrap = 1'b0;
        if (w_restart) begin
            w_scan_ptr = '0;
            w_scan_cnt = '0;
        end else if (w_adv) begin
            w_scan_ptr  = SEL_W'(r_ptr + SEL_W'(1));
            w_scan_cnt  = '0;
            w_scan_wrap = (r_ptr == SEL_W'(N_CH - 1));
        end else begin
            w_scan_cnt = CNT_W'(r_cnt + CNT_W'(1));
        end
    end

    // Channel data select for the sample about to be registered
    always_comb begin
        w_sel      = (w_state_nxt == ST_SCAN) ? w_scan_ptr : s;
        w_sel_data = '0;
        for (int k = 0; k < int'(N_CH); k++) begin
            if (w_sel == SEL_W'(k)) begin
                w_sel_data = d[k*W +: W];
            end
        end
    end

    // Output and scan-context next values for the state being entered
    always_comb begin
        w_ptr_nxt       = r_ptr;
        w_cnt_nxt       = r_cnt;
        w_last_scan_nxt = r_last_scan;
        w_y_nxt         = r_y;
        w_ch_nxt        = r_ch;
        w_y_valid_nxt   = 1'b0;
        w_wrap_nxt      = 1'b0;
        case (w_state_nxt)
            ST_MANUAL: begin
                w_y_nxt         = w_sel_data;
                w_ch_nxt        = s;
                w_y_valid_nxt   = 1'b1;
                w_last_scan_nxt = 1'b0;
            end
            ST_SCAN: begin
                w_ptr_nxt       = w_scan_ptr;
                w_cnt_nxt       = w_scan_cnt;
                w_y_nxt         = w_sel_data;
                w_ch_nxt        = w_scan_ptr;
                w_y_valid_nxt   = 1'b1;
                w_wrap_nxt      = w_scan_wrap;
                w_last_scan_nxt = 1'b1;
            end
            default: begin
                // IDLE: hold y/ch and freeze the scan position
            end
        endcase
    end

    // Output and scan-context registers
    always_ff @(posedge clk) begin
        if (rst) begin
            r_ptr       <= '0;
            r_cnt       <= '0;
            r_last_scan <= 1'b0;
            r_y         <= '0;
            r_ch        <= '0;
            r_y_valid   <= 1'b0;
            r_wrap      <= 1'b0;
        end else begin
            r_ptr       <= w_ptr_nxt;
            r_cnt       <= w_cnt_nxt;
            r_last_scan <= w_last_scan_nxt;
            r_y         <= w_y_nxt;
            r_ch        <= w_ch_nxt;
            r_y_valid   <= w_y_valid_nxt;
            r_wrap      <= w_wrap_nxt;
        end
    end

    assign y       = r_y;
    assign ch      = r_ch;
    assign y_valid = r_y_valid;
    assign wrap    = r_wrap;

endmodule

// File: tb/tb_chan_scan_mux.sv
// tb_chan_scan_mux: directed scenarios plus randomized traffic, every cycle
// compared against a behavioural model of the channel scanner.
module tb_chan_scan_mux;

    localparam int unsigned N_CH  = 8;
    localparam int unsigned W     = 4;
    localparam int unsigned SEL_W = $clog2(N_CH);
    localparam int unsigned D_W   = N_CH * W;

    logic               clk;
    logic               rst;
    logic [D_W-1:0]     d;
    logic [SEL_W-1:0]   s;
    logic               mode;
    logic               en;
    logic [7:0]         dwell;
    logic [W-1:0]       y;
    logic [SEL_W-1:0]   ch;
    logic               y_valid;
    logic               wrap;

    chan_scan_mux #(.N_CH(N_CH), .W(W)) dut (
        .clk     (clk),
        .rst     (rst),
        .d       (d),
        .s       (s),
        .mode    (mode),
        .en      (en),
        .dwell   (dwell),
        .y       (y),
        .ch      (ch),
        .y_valid (y_valid),
        .wrap    (wrap)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_chk = 0;
    int n_err = 0;
    int cyc   = 0;
    int wraps[$];

    // Reference model: what the viewer of y/ch should see
    int m_y, m_ch, m_valid, m_wrap;
    int m_pos;     // channel the scanner is on
    int m_shown;   // how many cycles that channel has been shown so far
    int m_last;    // last active mode: 0 none, 1 manual, 2 scan

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s cyc=%0d got=%0d exp=%0d", tag, cyc, got, exp);
        end
    endtask

    function automatic int chan_of(input logic [D_W-1:0] dv, input int k);
        logic [W-1:0] v;
        v = dv[k*W +: W];
        return int'(v);
    endfunction

    task automatic model_reset();
        m_y = 0; m_ch = 0; m_valid = 0; m_wrap = 0;
        m_pos = 0; m_shown = 0; m_last = 0;
    endtask

    task automatic model_step();
        if (rst) begin
            model_reset();
        end else if (!en) begin
            m_valid = 0;
            m_wrap  = 0;
        end else if (!mode) begin
            m_ch    = int'(s);
            m_y     = chan_of(d, int'(s));
            m_valid = 1;
            m_wrap  = 0;
            m_last  = 1;
        end else begin
            m_wrap = 0;
            if (m_last != 2) begin
                m_pos   = 0;
                m_shown = 1;
            end else if (m_shown > int'(dwell)) begin
                m_pos   = (m_pos + 1) % N_CH;
                m_shown = 1;
                m_wrap  = (m_pos == 0) ? 1 : 0;
            end else begin
                m_shown = m_shown + 1;
            end
            m_ch    = m_pos;
            m_y     = chan_of(d, m_pos);
            m_valid = 1;
            m_last  = 2;
        end
    endtask

    // One clock: model follows the inputs seen at the edge, then compare
    task automatic tick();
        @(posedge clk);
        model_step();
        #1;
        cyc++;
        check("y",       32'(y),       32'(m_y));
        check("ch",      32'(ch),      32'(m_ch));
        check("y_valid", 32'(y_valid), 32'(m_valid));
        check("wrap",    32'(wrap),    32'(m_wrap));
        if (wrap) wraps.push_back(cyc);
    endtask

    task automatic do_reset();
        rst = 1'b1;
        tick();
        rst = 1'b0;
    endtask

    initial begin
        int found;
        rst = 1'b1; en = 1'b0; mode = 1'b0; s = '0; dwell = 8'd0;
        d = D_W'($urandom);
        model_reset();
        tick();
        tick();
        check("rst_y",  32'(y), 32'd0);
        check("rst_ch", 32'(ch), 32'd0);
        rst = 1'b0;

        // Manual walk, d[k] = k+3
        for (int k = 0; k < int'(N_CH); k++) d[k*W +: W] = W'(k + 3);
        en = 1'b1; mode = 1'b0;
        for (int k = 0; k < int'(N_CH); k++) begin
            s = SEL_W'(k);
            tick();
            check("man_y", 32'(y), 32'(k + 3));
        end

        // Scan, dwell=0: period 8
        en = 1'b0; do_reset();
        wraps.delete();
        en = 1'b1; mode = 1'b1; dwell = 8'd0;
        for (int i = 0; i < 20; i++) begin
            d = D_W'($urandom);
            tick();
        end
        check("wrap_cnt0", 32'(wraps.size() >= 2), 32'd1);
        if (wraps.size() >= 2) check("period0", 32'(wraps[1] - wraps[0]), 32'd8);

        // Scan, dwell=2: period 24
        en = 1'b0; do_reset();
        wraps.delete();
        en = 1'b1; mode = 1'b1; dwell = 8'd2;
        for (int i = 0; i < 60; i++) begin
            d = D_W'($urandom);
            tick();
        end
        check("wrap_cnt2", 32'(wraps.size() >= 2), 32'd1);
        if (wraps.size() >= 2) check("period2", 32'(wraps[1] - wraps[0]), 32'd24);

        // Pause at ch=5 with cnt=1, then resume
        found = 0;
        for (int i = 0; i < 100 && found == 0; i++) begin
            tick();
            if (m_last == 2 && m_pos == 5 && m_shown == 2) found = 1;
        end
        check("find_ch5", 32'(found), 32'd1);
        en = 1'b0;
        for (int i = 0; i < 5; i++) tick();
        check("pause_ch", 32'(ch), 32'd5);
        en = 1'b1;
        tick();
        check("resume_ch5", 32'(ch), 32'd5);
        tick();
        check("resume_ch6", 32'(ch), 32'd6);

        // Mode hop at ch=4
        dwell = 8'd1;
        found = 0;
        for (int i = 0; i < 100 && found == 0; i++) begin
            tick();
            if (m_last == 2 && m_pos == 4) found = 1;
        end
        check("find_ch4", 32'(found), 32'd1);
        mode = 1'b0; s = SEL_W'(1);
        tick();
        tick();
        check("hop_ch1", 32'(ch), 32'd1);
        mode = 1'b1;
        tick();
        check("hop_ch0", 32'(ch), 32'd0);
        check("hop_nowrap", 32'(wrap), 32'd0);

        // Reset mid-scan at ch=6
        found = 0;
        for (int i = 0; i < 100 && found == 0; i++) begin
            tick();
            if (m_last == 2 && m_pos == 6) found = 1;
        end
        check("find_ch6", 32'(found), 32'd1);
        rst = 1'b1;
        tick();
        check("mid_rst_y",     32'(y), 32'd0);
        check("mid_rst_valid", 32'(y_valid), 32'd0);
        rst = 1'b0;
        tick();
        check("restart_ch", 32'(ch), 32'd0);

        // Randomized traffic
        for (int i = 0; i < 3000; i++) begin
            d   = D_W'($urandom);
            s   = SEL_W'($urandom);
            rst = ($urandom_range(0, 199) == 0);
            en  = ($urandom_range(0, 7) != 0);
            if ($urandom_range(0, 9) == 0) mode = ~mode;
            if ($urandom_range(0, 15) == 0)
                dwell = ($urandom_range(0, 3) == 0) ? 8'($urandom_range(0, 12))
                                                    : 8'($urandom_range(0, 3));
            tick();
        end

        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end

endmodule

// File: doc/chan_scan_mux.md
CHAN_SCAN_MUX -- requirements
Module: chan_scan_mux

Interface
REQ-001 The module SHALL have parameter N_CH, default 8, meaning the number of input channels; it SHALL be a power of 2, minimum 2.
REQ-002 The module SHALL have parameter W, default 1, meaning the data width per channel.
REQ-003 The module SHALL have localparam SEL_W = log2(N_CH), which sets the select and channel-index width.
REQ-004 The module SHALL have port clk, input, 1 bit: the single clock; all state updates on the rising edge.
REQ-005 The module SHALL have port rst, input, 1 bit: reset, synchronous and active-high.
REQ-006 The module SHALL have port d, input, N_CH*W bits: packed channel data; channel k occupies d[k*W +: W].
REQ-007 The module SHALL have port s, input, SEL_W bits: manual channel select.
REQ-008 The module SHALL have port mode, input, 1 bit: 0 = manual select, 1 = auto scan.
REQ-009 The module SHALL have port en, input, 1 bit: block enable.
REQ-010 The module SHALL have port dwell, input, 8 bits: extra cycles each channel is held in scan mode.
REQ-011 The module SHALL have port y, output, W bits: registered selected data.
REQ-012 The module SHALL have port ch, output, SEL_W bits: index of the channel currently driven on y.
REQ-013 The module SHALL have port y_valid, output, 1 bit: y/ch were updated from a live sample this cycle.
REQ-014 The module SHALL have port wrap, output, 1 bit: one-cycle pulse when scan advances from channel N_CH-1 to 0.

Function
REQ-015 The FSM SHALL have exactly three states: IDLE, MANUAL, SCAN.
REQ-016 Next-state rules SHALL be: en=0 -> IDLE; en=1 and mode=0 -> MANUAL; en=1 and mode=1 -> SCAN; evaluated every cycle.
REQ-017 MANUAL: each cycle y <= d[s], ch <= s, y_valid <= 1; latency s/d change to y is exactly 1 cycle.
REQ-018 SCAN: an internal channel pointer ptr and dwell counter cnt SHALL be kept; each cycle y <= d[ptr], ch <= ptr, y_valid <= 1.
REQ-019 SCAN: each channel SHALL be presented for dwell+1 consecutive cycles; dwell=0 advances ptr every cycle.
REQ-020 SCAN: when cnt reaches dwell, ptr <= ptr+1 modulo N_CH and cnt <= 0; otherwise cnt <= cnt+1.
REQ-021 wrap SHALL be 1 in the cycle after ptr advances from N_CH-1 to 0, i.e. concurrent with the first y of channel 0; otherwise 0.
REQ-022 Entering SCAN from MANUAL, or from IDLE when the last active state was MANUAL or none since reset, SHALL restart with ptr=0, cnt=0, and no wrap pulse.
REQ-023 Entering SCAN from IDLE when the last active state was SCAN SHALL resume at the frozen ptr/cnt.
REQ-024 IDLE: y and ch SHALL hold their last values, y_valid=0, wrap=0, and ptr/cnt SHALL be frozen.
REQ-025 A dwell change mid-channel SHALL take effect on the next comparison; if cnt already exceeds the new dwell, the channel SHALL advance on the next cycle.
REQ-026 A mode switch from SCAN to MANUAL SHALL take effect on the next edge with y <= d[s]; no wrap pulse is generated.
REQ-027 y SHALL be a pure W-bit copy of the selected channel; there is no arithmetic and no truncation.

Reset
REQ-028 On rst=1 at a clock edge: state=IDLE, y=0, ch=0, y_valid=0, wrap=0, ptr=0, cnt=0, last-active=none.
REQ-029 rst SHALL override en and mode; reset mid-scan discards position, and the next SCAN entry starts at channel 0.
REQ-030 The first y_valid after reset release SHALL occur 1 cycle after the first cycle with en=1.

Verification
REQ-031 Manual: N_CH=8, W=4, d[k]=k+3, en=1, mode=0, s stepped 0..7 once per cycle -> each cycle y=s+3 and ch=s one cycle later, y_valid=1.
REQ-032 Scan, dwell=0: en=1, mode=1 from reset -> ch sequence 0,1,...,7,0; wrap=1 only with the second ch=0; period 8 cycles.
REQ-033 Scan, dwell=2: -> each ch held exactly 3 cycles; wrap pulses every 24 cycles.
REQ-034 Pause/resume: en=0 for 5 cycles while ch=5 with cnt=1 -> y/ch held, y_valid=0; after en=1, ch=5 for 1 more cycle, then ch=6.
REQ-035 Mode hop: SCAN at ch=4 -> mode=0 with s=1 for 2 cycles -> ch=1; then mode=1 -> ch restarts at 0 with no wrap.
REQ-036 Reset mid-scan: rst=1 for 1 cycle at ch=6 -> y=0, ch=0, y_valid=0; with en=1 and mode=1, scan restarts at 0.
